// File: rtl/morse_symbol_assembler_if.sv
// rtl/morse_symbol_assembler_if.sv - symbol input, character stream and status bundle
interface morse_symbol_assembler_if;
    logic [2:0] ditsdahs;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic [2:0] sym_count;
    logic       overflow;
    logic       drop;

    modport master (
        output ditsdahs, char_ready,
        input  char_out, char_valid, sym_count, overflow, drop
    );

    modport slave (
        input  ditsdahs, char_ready,
        output char_out, char_valid, sym_count, overflow, drop
    );
endinterface

// File: rtl/morse_symbol_assembler.sv
// rtl/morse_symbol_assembler.sv - dit/dah pattern to ASCII translator with output character FIFO
module morse_symbol_assembler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    morse_symbol_assembler_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] C_WAIT  = 3'd0;
    localparam logic [2:0] C_DIT   = 3'd1;
    localparam logic [2:0] C_DAH   = 3'd2;
    localparam logic [2:0] C_GAP   = 3'd3;
    localparam logic [2:0] C_SPACE = 3'd4;

    typedef enum logic {COLLECT, EMIT_SPACE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  prev_q, code;
    logic [4:0]  pat_q, pat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        drop_q, drop_d;
    logic        last_space_q, last_space_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] occ_q;
    logic        ev, is_sym, push, pop, push_ok;
    logic [7:0]  push_char;

    // First symbol lands in the most significant used bit; 0 = dit, 1 = dah.
    function automatic logic [7:0] xlate(input logic [2:0] n, input logic [4:0] p);
        logic [7:0] c;
        c = 8'h3F;
        case (n)
            3'd1: c = p[0] ? "T" : "E";
            3'd2: case (p[1:0])
                2'b00: c = "I"; 2'b01: c = "A"; 2'b10: c = "N"; default: c = "M";
            endcase
            3'd3: case (p[2:0])
                3'b000: c = "S"; 3'b001: c = "U"; 3'b010: c = "R"; 3'b011: c = "W";
                3'b100: c = "D"; 3'b101: c = "K"; 3'b110: c = "G"; default: c = "O";
            endcase
            3'd4: case (p[3:0])
                4'b0000: c = "H"; 4'b0001: c = "V"; 4'b0010: c = "F"; 4'b0100: c = "L";
                4'b0110: c = "P"; 4'b0111: c = "J"; 4'b1000: c = "B"; 4'b1001: c = "X";
                4'b1010: c = "C"; 4'b1011: c = "Y"; 4'b1100: c = "Z"; 4'b1101: c = "Q";
                default: c = 8'h3F;
            endcase
            3'd5: case (p)
                5'b11111: c = "0"; 5'b01111: c = "1"; 5'b00111: c = "2"; 5'b00011: c = "3";
                5'b00001: c = "4"; 5'b00000: c = "5"; 5'b10000: c = "6"; 5'b11000: c = "7";
                5'b11100: c = "8"; 5'b11110: c = "9";
                default: c = 8'h3F;
            endcase
            default: c = 8'h3F;
        endcase
        return c;
    endfunction

    assign code   = (bus.ditsdahs > C_SPACE) ? C_WAIT : bus.ditsdahs;
    assign ev     = (code != C_WAIT) && ((prev_q == C_WAIT) || (code != prev_q));
    assign is_sym = ev && ((code == C_DIT) || (code == C_DAH));

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        last_space_d = last_space_q;
        push         = 1'b0;
        push_char    = 8'h20;

        // The pattern is already clear during EMIT_SPACE, so accumulation is shared.
        if (is_sym) begin
            pat_d = {pat_q[3:0], code == C_DAH};
            if (cnt_q != 3'd6) cnt_d = cnt_q + 3'd1;
            if (cnt_q >= 3'd5) ovf_d = 1'b1;
        end

        case (state_q)
            COLLECT: begin
                if (ev && (code == C_GAP) && (cnt_q != 3'd0)) begin
                    push      = 1'b1;
                    push_char = xlate(cnt_q, pat_q);
                    pat_d     = 5'd0;
                    cnt_d     = 3'd0;
                end else if (ev && (code == C_SPACE)) begin
                    if (cnt_q != 3'd0) begin
                        push      = 1'b1;
                        push_char = xlate(cnt_q, pat_q);
                        pat_d     = 5'd0;
                        cnt_d     = 3'd0;
                        state_d   = EMIT_SPACE;
                    end else if (!last_space_q) begin
                        push = 1'b1;
                    end
                end
            end
            EMIT_SPACE: begin
                push    = 1'b1;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        if (push) last_space_d = (push_char == 8'h20);
    end

    assign pop     = (occ_q != '0) && bus.char_ready;
    assign push_ok = push && ((occ_q != FULL) || pop);
    assign drop_d  = drop_q | (push & ~push_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            prev_q       <= C_WAIT;
            pat_q        <= 5'd0;
            cnt_q        <= 3'd0;
            ovf_q        <= 1'b0;
            drop_q       <= 1'b0;
            last_space_q <= 1'b1;
            wr_q         <= '0;
            rd_q         <= '0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= code;
            pat_q        <= pat_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
            last_space_q <= last_space_d;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_char;
    end

    assign bus.char_valid = (occ_q != '0);
    assign bus.char_out   = (occ_q != '0) ? mem_q[rd_q] : 8'h00;
    assign bus.sym_count  = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_morse_symbol_assembler.sv
// tb/tb_morse_symbol_assembler.sv - randomized and directed bench against a string-based Morse model
module tb_morse_symbol_assembler;
    localparam int DEPTH = 4;
    localparam logic [2:0] WAIT = 3'd0, DIT = 3'd1, DAH = 3'd2, GAP = 3'd3, SPACE = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    morse_symbol_assembler_if bus ();

    morse_symbol_assembler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                              "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                              "--...", "---..", "----."};

    logic [2:0] m_prev;
    string      m_pat;
    bit         m_last_space, m_space_next, m_ovf, m_drop;
    byte        m_q [$];
    byte        got [$];
    bit         rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic byte lookup(input string p);
        if (p.len() >= 6) return 8'h3F;
        for (int i = 0; i < 36; i++)
            if (morse_tab[i] == p) return (i < 26) ? byte'(8'h41 + i) : byte'(8'h30 + i - 26);
        return 8'h3F;
    endfunction

    function automatic logic [63:0] pack_got();
        logic [63:0] v = '0;
        foreach (got[i]) v = {v[55:0], got[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_prev = WAIT; m_pat = ""; m_last_space = 1'b1; m_space_next = 1'b0;
        m_ovf = 1'b0; m_drop = 1'b0; m_q.delete();
    endtask

    task automatic add_symbol(input logic [2:0] c);
        if (m_pat.len() < 6) m_pat = {m_pat, (c == DIT) ? "." : "-"};
        if (m_pat.len() == 6) m_ovf = 1'b1;
    endtask

    task automatic model_edge(input logic [2:0] c_in, input bit r);
        logic [2:0] c;
        bit  ev, has_push;
        byte ch;
        c = (c_in > SPACE) ? WAIT : c_in;
        ev = (c != WAIT) && ((m_prev == WAIT) || (c != m_prev));
        m_prev = c;
        has_push = 1'b0;
        ch = 8'h20;
        if (m_space_next) begin
            has_push = 1'b1;
            m_space_next = 1'b0;
            if (ev && (c == DIT || c == DAH)) add_symbol(c);
        end else if (ev) begin
            if (c == DIT || c == DAH) add_symbol(c);
            else if (m_pat.len() > 0) begin
                has_push = 1'b1;
                ch = lookup(m_pat);
                m_pat = "";
                if (c == SPACE) m_space_next = 1'b1;
            end else if (c == SPACE && !m_last_space) has_push = 1'b1;
        end
        if (m_q.size() > 0 && r) void'(m_q.pop_front());
        if (has_push) begin
            m_last_space = (ch == 8'h20);
            if (m_q.size() < DEPTH) m_q.push_back(ch);
            else m_drop = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("valid", bus.char_valid, m_q.size() != 0);
        check("char_out", bus.char_out, (m_q.size() != 0) ? m_q[0] : 8'h00);
        check("sym_count", bus.sym_count, m_pat.len());
        check("overflow", bus.overflow, m_ovf);
        check("drop", bus.drop, m_drop);
    endtask

    task automatic tick(input logic [2:0] c, input bit r);
        bus.ditsdahs = c;
        bus.char_ready = r;
        if (bus.char_valid && r) got.push_back(bus.char_out);
        @(posedge clk);
        model_edge(c, r);
        #1;
        compare_all();
    endtask

    task automatic sym(input logic [2:0] c);
        tick(c, rdy);
        tick(WAIT, rdy);
    endtask

    task automatic drain(input int n);
        repeat (n) tick(WAIT, rdy);
    endtask

    // Asserted between edges so reset values must appear with no clock edge.
    task automatic do_reset();
        reset = 1'b1;
        bus.ditsdahs = WAIT;
        #1;
        model_reset();
        compare_all();
        check("rst_valid", bus.char_valid, 1'b0);
        check("rst_sym", bus.sym_count, 3'd0);
        #2;
        reset = 1'b0;
        got.delete();
    endtask

    initial begin
        bus.ditsdahs = WAIT;
        bus.char_ready = 1'b0;
        rdy = 1'b1;
        #1;
        do_reset();

        tick(SPACE, rdy); tick(WAIT, rdy); drain(2);
        check("lead_space", got.size(), 0);

        repeat (3) sym(DIT); sym(GAP);
        repeat (3) sym(DAH); sym(GAP);
        repeat (3) sym(DIT); sym(GAP);
        drain(2);
        check("sos_len", got.size(), 3);
        check("sos", pack_got(), 64'h534F53);

        got.delete();
        sym(DIT); sym(DAH); sym(SPACE); sym(SPACE); drain(2);
        check("word_len", got.size(), 2);
        check("word", pack_got(), 64'h4120);

        do_reset();
        repeat (6) sym(DIT);
        check("sym6", bus.sym_count, 3'd6);
        sym(GAP); drain(2);
        check("ovf_char", pack_got(), 64'h3F);
        check("ovf_flag", bus.overflow, 1'b1);

        do_reset();
        sym(DIT); sym(DIT); sym(DAH); sym(DAH); sym(GAP); drain(2);
        check("unk_char", pack_got(), 64'h3F);
        check("unk_ovf", bus.overflow, 1'b0);

        do_reset();
        rdy = 1'b0;
        sym(DIT); sym(GAP); sym(DAH); sym(GAP); sym(DIT); sym(GAP);
        sym(DAH); sym(GAP); sym(DIT); sym(GAP);
        check("bp_drop", bus.drop, 1'b1);
        rdy = 1'b1; drain(6);
        check("bp_len", got.size(), 4);
        check("bp_seq", pack_got(), 64'h45544554);

        do_reset();
        rdy = 1'b0;
        sym(DIT); sym(GAP); sym(DAH); sym(GAP); sym(DIT); sym(GAP); sym(DAH); sym(GAP);
        tick(DIT, 1'b0); tick(WAIT, 1'b0); tick(GAP, 1'b1);
        rdy = 1'b1; drain(6);
        check("full_pp_len", got.size(), 5);
        check("full_pp_seq", pack_got(), 64'h4554455445);
        check("full_pp_drop", bus.drop, 1'b0);

        do_reset();
        repeat (10) tick(DIT, rdy);
        tick(WAIT, rdy); tick(GAP, rdy); drain(2);
        check("held_len", got.size(), 1);
        check("held", pack_got(), 64'h45);

        do_reset();
        rdy = 1'b0;
        sym(DIT); sym(GAP); sym(DAH); sym(DAH);
        check("pre_rst_sym", bus.sym_count, 3'd2);
        check("pre_rst_valid", bus.char_valid, 1'b1);
        do_reset();
        rdy = 1'b1;
        sym(GAP); drain(2);
        check("post_rst_none", got.size(), 0);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [2:0] c;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: c = WAIT;
                3, 4:    c = DIT;
                5, 6:    c = DAH;
                7:       c = GAP;
                8:       c = SPACE;
                default: c = 3'($urandom_range(5, 7));
            endcase
            tick(c, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/morse_symbol_assembler.md
# morse_symbol_assembler

Downstream stage of the dit/dah decoder. Consumes the 3-bit symbol code stream (`WAIT`/`DIT`/`DAH`/`GAP`/`SPACE`), accumulates dits and dahs into a pattern, translates each completed pattern to ASCII on a letter gap, and inserts a space character on a word gap. Characters are buffered in a small FIFO and offered to the display/UART stage over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: output character FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset; all state cleared.
- `ditsdahs`  in  3  symbol code, synchronous to `clk`: 0=`WAIT`, 1=`DIT`, 2=`DAH`, 3=`GAP`, 4=`SPACE`, 5–7 treated as `WAIT`.
- `char_out`  out  8  ASCII character at FIFO head.
- `char_valid`  out  1  FIFO non-empty.
- `char_ready`  in  1  consumer accepts `char_out` this cycle.
- `sym_count`  out  3  symbols in the current pattern, 0–5; 6 = overflowed.
- `overflow`  out  1  sticky: a pattern exceeded 5 symbols.
- `drop`  out  1  sticky: a character was discarded because the FIFO was full.

## Operation
- Event detection: register `prev_code` (reset `WAIT`). An event fires in a cycle where `ditsdahs` ≠ `WAIT`, and either `prev_code` = `WAIT` or `ditsdahs` ≠ `prev_code`. A code held for many cycles is one event.
- Pattern register: 5 bits plus `sym_count`. Each `DIT` (0) or `DAH` (1) shifts in at the LSB, so the first symbol ends up at the most significant used bit. `sym_count` increments and saturates at 6. Reaching 6 sets `overflow`.
- Translation: standard ITU Morse for A–Z (uppercase) and 0–9. Examples: E = len1 `0`, T = len1 `1`, A = len2 `01`, S = len3 `000`, O = len3 `111`, 0 = len5 `11111`. Any unlisted pattern or `sym_count` = 6 produces `?` (0x3F).
- FSM states:
  - `COLLECT` (reset state)
    - `DIT`/`DAH`: accumulate.
    - `GAP` with `sym_count` > 0: push the translated char, clear the pattern, stay in `COLLECT`.
    - `GAP` with `sym_count` = 0: ignored.
    - `SPACE` with `sym_count` > 0: push the translated char, clear the pattern, go to `EMIT_SPACE`.
    - `SPACE` with `sym_count` = 0: push 0x20 unless `last_space` is set.
  - `EMIT_SPACE` (one cycle): push 0x20 unconditionally, return to `COLLECT`.
    - A `DIT`/`DAH` event in this cycle is accumulated into the cleared pattern.
    - `GAP`/`SPACE` events in this cycle are ignored.
- `last_space` flag: reset 1, so leading spaces are suppressed. Set on a 0x20 push, cleared on any other push. It also applies to consecutive `SPACE` events, so repeated word gaps collapse to one space.
- `drop` and `overflow` are cleared only by reset.

## Timing
- Reset values:
  - `char_out` = 0x00, `char_valid` = 0, `sym_count` = 0, `overflow` = 0, `drop` = 0.
  - FIFO empty, state `COLLECT`, `prev_code` = `WAIT`.
- Latency:
  - A `GAP` event sampled at edge t pushes at edge t; `char_valid` is high from after edge t.
  - For `SPACE` with a pending pattern, the char pushes at t and 0x20 at t+1.
- FIFO push and pop:
  - A pop occurs at an edge where `char_valid` && `char_ready`.
  - A push when full is accepted only if a pop occurs at the same edge. Otherwise the character is discarded, `drop` sets, and FIFO contents are unchanged.
  - Simultaneous push and pop on an empty FIFO: no pop (nothing valid), push accepted.
- `char_out` is stable while `char_valid` && !`char_ready`.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter width is log2(`FIFO_DEPTH`)+1.
- Reset asserted mid-pattern or mid-`EMIT_SPACE` aborts immediately. No partial character is emitted after release.

## Test plan
- S-O-S: `DIT`×3, `GAP`, `DAH`×3, `GAP`, `DIT`×3, `GAP` (each separated by `WAIT`), `char_ready`=1 → `char_out` sequence 0x53, 0x4F, 0x53; `sym_count` returns to 0 after each `GAP`.
- Word gap: `DIT`, `DAH`, `SPACE`, then `SPACE` again → 0x41 at t, 0x20 at t+1, no second 0x20. A `SPACE` immediately after reset → nothing pushed.
- Overflow / unknown: 6×`DIT` then `GAP` → 0x3F pushed, `overflow`=1, `sym_count` showed 6. `DIT`,`DIT`,`DAH`,`DAH`,`GAP` → 0x3F, `overflow` stays 0.
- Backpressure: `char_ready`=0, five letters E T E T E with `FIFO_DEPTH`=4 → `drop`=1. Releasing ready yields exactly 0x45, 0x54, 0x45, 0x54. A push on the same edge as a pop when full is accepted.
- Held code: `ditsdahs`=`DIT` held 10 cycles, then `WAIT`, then `GAP` → single 0x45.
- Async reset: assert `reset` between edges after `DAH`,`DAH` → outputs take reset values without a clock edge; a following `GAP` emits nothing.
